// File: rtl/alu_sequencer.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) that fetches operands, drives the ALU, keeps Z/C flags and writes back.
// Optional illegal-op trap: define ALU_SEQ_ILLEGAL_TRAP_EN to make op F raise a sticky err.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  rf_ra1,
  output logic [2:0]  rf_ra2,
  input  logic [7:0]  rf_rd1,
  input  logic [7:0]  rf_rd2,
  output logic        rf_we,
  output logic [2:0]  rf_wa,
  output logic [7:0]  rf_wd,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_carry_in,
  output logic        alu_is_shift,
  output logic [1:0]  alu_scode,
  output logic [2:0]  alu_acode,
  input  logic [7:0]  alu_r,
  input  logic        alu_zero,
  input  logic        alu_carry_out,
  output logic        flag_z,
  output logic        flag_c,
  output logic        done,
  output logic        err
);

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned IW  = 16;
  localparam int unsigned OPW = 4;
  localparam int unsigned SHW = 3;
  localparam logic [2:0] ACODE_IDLE = 3'b111;
  localparam logic [2:0] ACODE_SUB  = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_instr, w_instr_nxt;
  logic            r_instr_ready, w_ready_nxt;
  logic [AW-1:0]   r_rf_ra1, w_ra1_nxt, r_rf_ra2, w_ra2_nxt;
  logic            r_rf_we, w_we_nxt;
  logic [AW-1:0]   r_rf_wa, w_wa_nxt;
  logic [DW-1:0]   r_rf_wd, w_wd_nxt;
  logic [DW-1:0]   r_alu_a, w_alu_a_nxt, r_alu_b, w_alu_b_nxt;
  logic            r_alu_cin, w_alu_cin_nxt;
  logic            r_alu_shift, w_alu_shift_nxt;
  logic [1:0]      r_alu_scode, w_alu_scode_nxt;
  logic [2:0]      r_alu_acode, w_alu_acode_nxt;
  logic            r_flag_z, w_z_nxt, r_flag_c, w_c_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;

  // Decode of the latched instruction; live instr is only looked at in IDLE.
  logic [OPW-1:0]  w_op;
  logic [AW-1:0]   w_rd;
  logic [SHW-1:0]  w_sh;
  logic            w_alu_op, w_shift, w_arith, w_logic, w_writes;

  assign w_op     = r_instr[15:12];
  assign w_rd     = r_instr[11:9];
  assign w_sh     = r_instr[2:0];
  assign w_alu_op = (w_op <= 4'hB);
  assign w_shift  = (w_op[3:2] == 2'b10);
  assign w_arith  = (w_op <= 4'h3) || (w_op == 4'h7);
  assign w_logic  = (w_op >= 4'h4) && (w_op <= 4'h6);
  assign w_writes = (w_op <= 4'h6) || w_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_instr       <= '0;
      r_instr_ready <= 1'b1;
      r_rf_ra1      <= '0;
      r_rf_ra2      <= '0;
      r_rf_we       <= 1'b0;
      r_rf_wa       <= '0;
      r_rf_wd       <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_cin     <= 1'b0;
      r_alu_shift   <= 1'b0;
      r_alu_scode   <= 2'b00;
      r_alu_acode   <= ACODE_IDLE;
      r_flag_z      <= 1'b0;
      r_flag_c      <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_ready <= w_ready_nxt;
      r_rf_ra1      <= w_ra1_nxt;
      r_rf_ra2      <= w_ra2_nxt;
      r_rf_we       <= w_we_nxt;
      r_rf_wa       <= w_wa_nxt;
      r_rf_wd       <= w_wd_nxt;
      r_alu_a       <= w_alu_a_nxt;
      r_alu_b       <= w_alu_b_nxt;
      r_alu_cin     <= w_alu_cin_nxt;
      r_alu_shift   <= w_alu_shift_nxt;
      r_alu_scode   <= w_alu_scode_nxt;
      r_alu_acode   <= w_alu_acode_nxt;
      r_flag_z      <= w_z_nxt;
      r_flag_c      <= w_c_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
    end
  end

  // Next-state logic; outputs are computed for the state being entered so they register cleanly.
  always_comb begin
    w_state_nxt     = r_state;
    w_instr_nxt     = r_instr;
    w_ready_nxt     = r_instr_ready;
    w_ra1_nxt       = r_rf_ra1;
    w_ra2_nxt       = r_rf_ra2;
    w_we_nxt        = 1'b0;
    w_wa_nxt        = r_rf_wa;
    w_wd_nxt        = r_rf_wd;
    w_done_nxt      = 1'b0;
    w_alu_a_nxt     = '0;
    w_alu_b_nxt     = '0;
    w_alu_cin_nxt   = 1'b0;
    w_alu_shift_nxt = 1'b0;
    w_alu_scode_nxt = 2'b00;
    w_alu_acode_nxt = ACODE_IDLE;
    w_z_nxt         = r_flag_z;
    w_c_nxt         = r_flag_c;
    w_err_nxt       = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (instr_valid && r_instr_ready) begin
          w_instr_nxt = instr;
          w_ra1_nxt   = instr[8:6];
          w_ra2_nxt   = instr[5:3];
          w_ready_nxt = 1'b0;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_state_nxt = S_EXEC;
        if (w_alu_op) begin
          w_alu_a_nxt     = rf_rd1;
          w_alu_b_nxt     = w_shift ? {5'b0, w_sh} : rf_rd2;
          w_alu_cin_nxt   = r_flag_c;
          w_alu_shift_nxt = w_shift;
          if (w_shift) w_alu_scode_nxt = w_op[1:0];
          else         w_alu_acode_nxt = (w_op == 4'h7) ? ACODE_SUB : w_op[2:0];
        end
      end
      S_EXEC: begin
        w_state_nxt = S_WB;
        w_done_nxt  = 1'b1;
        if (w_writes) begin
          w_we_nxt = 1'b1;
          w_wa_nxt = w_rd;
          w_wd_nxt = alu_r;
        end
        if (w_arith) begin
          w_z_nxt = alu_zero;
          w_c_nxt = alu_carry_out;
        end else if (w_logic) begin
          w_z_nxt = alu_zero;
        end else if (w_shift) begin
          w_z_nxt = alu_zero;
          if (w_sh != 3'd0) w_c_nxt = alu_carry_out;
        end else if (w_op == 4'hC) begin
          w_c_nxt = 1'b0;
        end else if (w_op == 4'hD) begin
          w_c_nxt = 1'b1;
        end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (w_op == 4'hF) w_err_nxt = 1'b1;
`endif
      end
      S_WB: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = !r_err;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign instr_ready  = r_instr_ready;
  assign rf_ra1       = r_rf_ra1;
  assign rf_ra2       = r_rf_ra2;
  assign rf_we        = r_rf_we;
  assign rf_wa        = r_rf_wa;
  assign rf_wd        = r_rf_wd;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_carry_in = r_alu_cin;
  assign alu_is_shift = r_alu_shift;
  assign alu_scode    = r_alu_scode;
  assign alu_acode    = r_alu_acode;
  assign flag_z       = r_flag_z;
  assign flag_c       = r_flag_c;
  assign done         = r_done;
  assign err          = r_err;

endmodule
